// File: rtl/frame_sequencer.sv
// Frame controller for the sprite pipeline: clears the back buffer, gates the
// sprite draw phase, and swaps front/back buffers on vsync once drawing settles.
module frame_sequencer #(
    parameter int FB_PIXELS     = 307200,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        frame_end,
    input  logic [3:0]  clear_color,
    input  logic        vsync,
    input  logic        sprite_queue_is_empty,
    input  logic        sprite0_busy,
    input  logic        sprite1_busy,
    output logic        fb_resetting,
    output logic [18:0] clr_wr1_addr,
    output logic [18:0] clr_wr2_addr,
    output logic [3:0]  clr_data,
    output logic        clr_en,
    output logic        draw_enable,
    output logic        fb_select,
    output logic        frame_done,
    output logic        busy
);

    localparam int          IDLE_W   = $clog2(SETTLE_CYCLES + 1);
    localparam logic [18:0] LAST_ODD = 19'(FB_PIXELS - 1);
    localparam logic [IDLE_W-1:0] SETTLE = IDLE_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DRAW,
        WAIT_VSYNC
    } state_t;

    state_t            state, state_next;
    logic [17:0]       k, k_next;
    logic              submitted, submitted_next;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_next;
    logic [3:0]        clr_data_next;
    logic              fb_select_next;
    logic              frame_done_next;
    logic              all_idle;
    logic [18:0]       odd_addr;

    assign all_idle = submitted && sprite_queue_is_empty && !sprite0_busy && !sprite1_busy;
    assign odd_addr = {k, 1'b1};

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        state_next      = state;
        k_next          = k;
        submitted_next  = submitted;
        idle_cnt_next   = idle_cnt;
        clr_data_next   = clr_data;
        fb_select_next  = fb_select;
        frame_done_next = 1'b0;

        case (state)
            IDLE: begin
                if (frame_start) begin
                    clr_data_next  = clear_color;
                    k_next         = '0;
                    submitted_next = 1'b0;
                    idle_cnt_next  = '0;
                    state_next     = CLEAR;
                end
            end
            CLEAR: begin
                if (frame_end) submitted_next = 1'b1;
                if (odd_addr == LAST_ODD) begin
                    k_next     = '0;
                    state_next = DRAW;
                end else begin
                    k_next = k + 18'd1;
                end
            end
            DRAW: begin
                if (frame_end) submitted_next = 1'b1;
                if (all_idle) begin
                    idle_cnt_next = idle_cnt + 1'b1;
                    if (idle_cnt_next == SETTLE) begin
                        idle_cnt_next = '0;
                        state_next    = WAIT_VSYNC;
                    end
                end else begin
                    idle_cnt_next = '0;
                end
            end
            WAIT_VSYNC: begin
                if (vsync) begin
                    fb_select_next  = !fb_select;
                    frame_done_next = 1'b1;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with
    // the state they describe.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            k            <= '0;
            submitted    <= 1'b0;
            idle_cnt     <= '0;
            clr_data     <= '0;
            fb_select    <= 1'b0;
            frame_done   <= 1'b0;
            fb_resetting <= 1'b0;
            clr_en       <= 1'b0;
            clr_wr1_addr <= '0;
            clr_wr2_addr <= '0;
            draw_enable  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            k            <= k_next;
            submitted    <= submitted_next;
            idle_cnt     <= idle_cnt_next;
            clr_data     <= clr_data_next;
            fb_select    <= fb_select_next;
            frame_done   <= frame_done_next;
            fb_resetting <= (state_next == CLEAR);
            clr_en       <= (state_next == CLEAR);
            clr_wr1_addr <= (state_next == CLEAR) ? {k_next, 1'b0} : 19'd0;
            clr_wr2_addr <= (state_next == CLEAR) ? {k_next, 1'b1} : 19'd0;
            draw_enable  <= (state_next == DRAW);
            busy         <= (state_next != IDLE);
        end
    end

endmodule
